hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 16-bit five-stage core. It tracks destination registers in flight in EX and MEM, stalls the IF and ID stages on read-after-write hazards, and flushes wrong-path instructions on taken branches. It also drains the pipeline on a halt instruction. It drives the PC `hold` input and the IF/ID and ID/EX register controls, replacing the constant `hold = 0`.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hz_scoreboard.sv | 47 ++++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by hazard_ctrl and hz_scoreboard.
package hazard_pkg;

    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic              vld;
        logic [AW_DEF-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Two-entry destination scoreboard (EX, MEM) with a hit flag per ID source port.
// A WB-stage writer is not tracked: the register file writes early in WB.
module hz_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic            wr_vld,
    input  logic [AW-1:0]   wr_rd,
    input  logic [2*AW-1:0] rs_addr,
    output logic [1:0]      rs_hit,
    output logic            busy
);

    logic          ex_vld_reg;
    logic [AW-1:0] ex_rd_reg;
    logic          mem_vld_reg;
    logic [AW-1:0] mem_rd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_reg  <= 1'b0;
            ex_rd_reg   <= '0;
            mem_vld_reg <= 1'b0;
            mem_rd_reg  <= '0;
        end else begin
            ex_vld_reg  <= issue & wr_vld;
            ex_rd_reg   <= wr_rd;
            mem_vld_reg <= ex_vld_reg;
            mem_rd_reg  <= ex_rd_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign rs_hit[gi] = (ex_vld_reg  && (ex_rd_reg  == rs_addr[gi*AW +: AW])) ||
                                (mem_vld_reg && (mem_rd_reg == rs_addr[gi*AW +: AW]));
        end
    endgenerate

    assign busy = ex_vld_reg | mem_vld_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: RAW stalls, branch flushes, HLT drain.
// Define STAT_EN to add saturating stall/flush statistics counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW = AW_DEF
`ifdef STAT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs0,
    input  logic [AW-1:0] id_rs1,
    input  logic          id_rs0_vld,
    input  logic          id_rs1_vld,
    input  logic [AW-1:0] id_rd,
    input  logic          id_rd_vld,
    input  logic          id_halt,
    input  logic          ex_branch_taken,
    output logic          hold,
    output logic          ifid_stall,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic          halted
`ifdef STAT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_DRAIN  = DRAIN;
    localparam logic [1:0] S_HALTED = HALTED;

    logic [1:0] state_reg, state_next;
    logic       drain_wait_reg, drain_wait_next;
    logic [1:0] rs_hit;
    logic       sb_busy;
    logic       raw;
    logic       issued;

    assign raw    = id_valid & ((id_rs0_vld & rs_hit[0]) | (id_rs1_vld & rs_hit[1]));
    assign issued = id_valid & ~raw & ~ex_branch_taken & (state_reg == S_RUN);

    hz_scoreboard #(.AW(AW)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .issue   (issued),
        .wr_vld  (id_rd_vld),
        .wr_rd   (id_rd),
        .rs_addr ({id_rs1, id_rs0}),
        .rs_hit  (rs_hit),
        .busy    (sb_busy)
    );

    // DRAIN waits one cycle past an empty scoreboard so the last writer retires in WB.
    always_comb begin
        state_next      = state_reg;
        drain_wait_next = 1'b0;
        case (state_reg)
            S_RUN: begin
                if (id_halt && issued)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (ex_branch_taken) begin
                    state_next = S_RUN;
                end else if (!sb_busy) begin
                    if (drain_wait_reg)
                        state_next = S_HALTED;
                    else
                        drain_wait_next = 1'b1;
                end
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_RUN;
            drain_wait_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            drain_wait_reg <= drain_wait_next;
        end
    end

    always_comb begin
        hold        = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (raw) begin
                        hold        = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A taken branch here means HLT was wrong-path: let the redirect fetch.
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        hold        = 1'b1;
                        ifid_flush  = 1'b1;
                    end
                end
                S_HALTED: begin
                    hold        = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef STAT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;
    logic             stall_inc;

    assign stall_inc = raw & ~ex_branch_taken & (state_reg == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_inc && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (ex_branch_taken && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counter checks appear when STAT_EN is defined.
module tb_hazard_ctrl;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11010;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_DRAIN = 5'b10100;
    localparam logic [4:0] C_HALT  = 5'b10111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs0 = '0;
    logic [3:0] id_rs1 = '0;
    logic       id_rs0_vld = 1'b0;
    logic       id_rs1_vld = 1'b0;
    logic [3:0] id_rd = '0;
    logic       id_rd_vld = 1'b0;
    logic       id_halt = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       hold, ifid_stall, ifid_flush, idex_bubble, halted;
    logic [4:0] ctrl;
`ifdef STAT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs0          (id_rs0),
        .id_rs1          (id_rs1),
        .id_rs0_vld      (id_rs0_vld),
        .id_rs1_vld      (id_rs1_vld),
        .id_rd           (id_rd),
        .id_rd_vld       (id_rd_vld),
        .id_halt         (id_halt),
        .ex_branch_taken (ex_branch_taken),
        .hold            (hold),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted)
`ifdef STAT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    assign ctrl = {hold, ifid_stall, ifid_flush, idex_bubble, halted};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One call = one clock cycle with the given instruction in ID; returns mid-cycle, outputs settled.
    task automatic cyc(input logic v, input logic [3:0] r0, input logic r0v,
                       input logic [3:0] r1, input logic r1v,
                       input logic [3:0] rd, input logic rdv,
                       input logic hlt, input logic br);
        @(posedge clk); #1;
        id_valid = v; id_rs0 = r0; id_rs0_vld = r0v; id_rs1 = r1; id_rs1_vld = r1v;
        id_rd = rd; id_rd_vld = rdv; id_halt = hlt; ex_branch_taken = br;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL rst_outputs: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   rst_outputs ctrl=%b", ctrl);
        idle();
        rst = 1'b0; #1;
        idle();
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL post_rst_idle: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   post_rst_idle ctrl=%b", ctrl);
`ifdef STAT_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters: stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt); end
        else $display("ok   rst_counters");
`endif
    endtask

    task automatic test_raw_ex();
        int n;
        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL raw_ex_writer: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   raw_ex_writer issued");
        cyc(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_STALL) begin errors++; $display("FAIL raw_ex_stall: ctrl=%b expected %b", ctrl, C_STALL); end
        else $display("ok   raw_ex_stall ctrl=%b", ctrl);
        n = 0;
        while (hold === 1'b1 && n < 8) begin
            n++;
            cyc(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (n !== 2 || ctrl !== C_IDLE) begin errors++; $display("FAIL raw_ex_len: stalls=%0d ctrl=%b expected 2 %b", n, ctrl, C_IDLE); end
        else $display("ok   raw_ex_len stalls=%0d", n);
        exp_stall += 2;

        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL src_vld_gate: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   src_vld_gate no stall");

        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_STALL) begin errors++; $display("FAIL r0_not_special: ctrl=%b expected %b", ctrl, C_STALL); end
        else $display("ok   r0_not_special ctrl=%b", ctrl);
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        exp_stall += 2;
    endtask

    task automatic test_raw_mem();
        int n;
        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (hold === 1'b1 && n < 8) begin
            n++;
            cyc(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (n !== 1) begin errors++; $display("FAIL raw_mem_len: stalls=%0d expected 1", n); end
        else $display("ok   raw_mem_len stalls=%0d", n);
        exp_stall += 1;

        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL raw_wb_none: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   raw_wb_none no stall");
    endtask

    task automatic test_branch();
        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1);
        checks++;
        if (ctrl !== C_FLUSH) begin errors++; $display("FAIL branch_over_raw: ctrl=%b expected %b", ctrl, C_FLUSH); end
        else $display("ok   branch_over_raw ctrl=%b", ctrl);
        exp_flush += 1;
        cyc(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL branch_kill_sb: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   branch_kill_sb killed rd not tracked");
`ifdef STAT_EN
        checks++;
        if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
            errors++; $display("FAIL stat_counts: stall=%0d flush=%0d expected %0d %0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end else $display("ok   stat_counts stall=%0d flush=%0d", stall_cnt, flush_cnt);
`endif
    endtask

    task automatic test_halt_branch();
        int h;
        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle();
        checks++;
        if (ctrl !== C_DRAIN) begin errors++; $display("FAIL drain_ctrl: ctrl=%b expected %b", ctrl, C_DRAIN); end
        else $display("ok   drain_ctrl ctrl=%b", ctrl);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctrl !== C_FLUSH) begin errors++; $display("FAIL drain_branch: ctrl=%b expected %b", ctrl, C_FLUSH); end
        else $display("ok   drain_branch redirect");
        exp_flush += 1;
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_STALL) begin errors++; $display("FAIL drain_resume: ctrl=%b expected %b", ctrl, C_STALL); end
        else $display("ok   drain_resume issuing again");
        h = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) cyc(1'b1, 4'd11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            else idle();
            if (halted === 1'b1) h++;
        end
        checks++;
        if (h !== 0) begin errors++; $display("FAIL drain_no_halt: halted cycles=%0d expected 0", h); end
        else $display("ok   drain_no_halt");
        exp_stall += 2;
    endtask

    task automatic test_halt_raw();
        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctrl !== C_STALL) begin errors++; $display("FAIL halt_raw_stall: ctrl=%b expected %b", ctrl, C_STALL); end
        else $display("ok   halt_raw_stall ctrl=%b", ctrl);
        cyc(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL halt_raw_issue: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   halt_raw_issue");
        idle();
        checks++;
        if (ctrl !== C_DRAIN) begin errors++; $display("FAIL halt_raw_drain: ctrl=%b expected %b", ctrl, C_DRAIN); end
        else $display("ok   halt_raw_drain");
        exp_stall += 2;
        rst = 1'b1;
        idle();
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL rst_in_drain: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   rst_in_drain");
        rst = 1'b0; #1;
        exp_stall = 0; exp_flush = 0;
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL rst_drain_run: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   rst_drain_run back in RUN");
    endtask

    task automatic test_halt_drain();
        int n;
        idle(); idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        idle();
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL hlt_issue: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   hlt_issue");
        n = 0;
        while (halted !== 1'b1 && n < 10) begin
            idle();
            n++;
        end
        checks++;
        if (n !== 3 || ctrl !== C_HALT) begin errors++; $display("FAIL halt_latency: cycles=%0d ctrl=%b expected 3 %b", n, ctrl, C_HALT); end
        else $display("ok   halt_latency cycles=%0d", n);
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_HALT) begin errors++; $display("FAIL halted_no_issue: ctrl=%b expected %b", ctrl, C_HALT); end
        else $display("ok   halted_no_issue");
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctrl !== C_HALT) begin errors++; $display("FAIL halted_sticky: ctrl=%b expected %b", ctrl, C_HALT); end
        else $display("ok   halted_sticky");
    endtask

    task automatic test_rst_halted();
        rst = 1'b1;
        cyc(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL rst_in_halted: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   rst_in_halted");
        rst = 1'b0; #1;
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL halted_rst_run: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   halted_rst_run");
        cyc(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_STALL) begin errors++; $display("FAIL pre_rst_stall: ctrl=%b expected %b", ctrl, C_STALL); end
        else $display("ok   pre_rst_stall");
        rst = 1'b1;
        cyc(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL rst_midstall: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   rst_midstall");
        rst = 1'b0; #1;
        cyc(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== C_IDLE) begin errors++; $display("FAIL post_rst_no_stall: ctrl=%b expected %b", ctrl, C_IDLE); end
        else $display("ok   post_rst_no_stall");
`ifdef STAT_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_clears_counts: stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt); end
        else $display("ok   rst_clears_counts");
`endif
    endtask

    initial begin
        test_reset();
        test_raw_ex();
        test_raw_mem();
        test_branch();
        test_halt_branch();
        test_halt_raw();
        test_halt_drain();
        test_rst_halted();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
